// File: rtl/afifo_reader.sv
// afifo_reader: read-clock-domain burst drain engine for the async FIFO.
// Define AFIFO_READER_HDR_EN to prefix every burst with a sequence-number header word.
module afifo_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                  rdclk,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_rdempty,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_POP = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef AFIFO_READER_HDR_EN
        HDR    = 2'd1,
`endif
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      pops_q, pops_d;
    logic                  in_flight_q, in_flight_d;
    logic                  in_flight_last_q, in_flight_last_d;
    logic [DATA_WIDTH:0]   mem_q [4];
    logic [DATA_WIDTH:0]   mem_d [4];
    logic [1:0]            wr_q, wr_d;
    logic [1:0]            rd_q, rd_d;
    logic [2:0]            count_q, count_d;
`ifdef AFIFO_READER_HDR_EN
    logic [DATA_WIDTH-1:0] seq_q, seq_d;
`endif

    logic                  xfer;
    logic                  last_pop;
    logic                  push;
    logic [DATA_WIDTH:0]   push_word;
    logic [3:0]            occupancy;

    always_ff @(posedge rdclk) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en && !fifo_rdempty) begin
`ifdef AFIFO_READER_HDR_EN
                    state_d = HDR;
`else
                    state_d = STREAM;
`endif
                end
            end
`ifdef AFIFO_READER_HDR_EN
            HDR:     state_d = STREAM;
`endif
            STREAM:  if (last_pop) state_d = DRAIN;
            DRAIN:   if (xfer && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Words already popped but not yet captured count against the 4-entry buffer.
    always_comb begin
        occupancy  = 4'(count_q) + 4'(in_flight_q);
        busy       = (state_q != IDLE);
        fifo_rdreq = !clear && !fifo_rdempty && (state_q == STREAM)
                     && (pops_q < FULL_CNT) && (occupancy < 4'd4);
        out_valid  = (count_q != 3'd0);
        {out_last, out_data} = mem_q[rd_q];
    end

    always_comb begin
        xfer      = out_valid && out_ready;
        last_pop  = fifo_rdreq && (pops_q == LAST_POP);
        push      = 1'b0;
        push_word = '0;
        if (in_flight_q) begin
            push      = 1'b1;
            push_word = {in_flight_last_q, fifo_q};
        end
`ifdef AFIFO_READER_HDR_EN
        else if (state_q == HDR) begin
            push      = 1'b1;
            push_word = {1'b0, seq_q};
        end
`endif
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = push_word;
        end
        wr_d             = wr_q + 2'(push);
        rd_d             = rd_q + 2'(xfer);
        count_d          = count_q + 3'(push) - 3'(xfer);
        in_flight_d      = fifo_rdreq;
        in_flight_last_d = last_pop;
        pops_d           = (state_q == IDLE) ? '0 : pops_q + CNT_W'(fifo_rdreq);
`ifdef AFIFO_READER_HDR_EN
        seq_d            = seq_q + DATA_WIDTH'(state_q == DRAIN && xfer && out_last);
`endif
    end

    // Clearing in_flight_q drops a word returning from a pop issued just before clear.
    always_ff @(posedge rdclk) begin
        if (clear) begin
            pops_q           <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            mem_q            <= '{default: '0};
            wr_q             <= '0;
            rd_q             <= '0;
            count_q          <= '0;
`ifdef AFIFO_READER_HDR_EN
            seq_q            <= '0;
`endif
        end else begin
            pops_q           <= pops_d;
            in_flight_q      <= in_flight_d;
            in_flight_last_q <= in_flight_last_d;
            mem_q            <= mem_d;
            wr_q             <= wr_d;
            rd_q             <= rd_d;
            count_q          <= count_d;
`ifdef AFIFO_READER_HDR_EN
            seq_q            <= seq_d;
`endif
        end
    end

endmodule

// File: tb/tb_afifo_reader.sv
// Scoreboard bench for afifo_reader (BURST_LEN=4); expectations follow AFIFO_READER_HDR_EN.
module tb_afifo_reader;

    localparam int unsigned BL = 4;
`ifdef AFIFO_READER_HDR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic       clk = 1'b0;
    logic       clear, en, fifo_rdempty, fifo_rdreq;
    logic       out_valid, out_ready, out_last, busy;
    logic [7:0] fifo_q, out_data;

    logic [7:0] fifo_mem [256];
    int         wr_idx = 0;
    int         rd_idx = 0;
    int         n_pops = 0;
    int         n_dx;
    int         errors = 0;
    int         checks = 0;
    logic [9:0] exp_q [$];
    logic [7:0] exp_seq;
    logic       rdy_alt;

    afifo_reader #(.DATA_WIDTH(8), .BURST_LEN(BL)) dut (
        .rdclk(clk), .clear(clear), .en(en), .fifo_q(fifo_q),
        .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    assign fifo_rdempty = (rd_idx == wr_idx);

    // FIFO read port with one-cycle registered latency, flushed by clear.
    always @(posedge clk) begin
        if (clear) begin
            rd_idx <= wr_idx;
            n_pops <= 0;
        end else if (fifo_rdreq) begin
            fifo_q <= fifo_mem[rd_idx[7:0]];
            rd_idx <= rd_idx + 1;
            n_pops <= n_pops + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [7:0] base, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            if (H == 1 && (i % BL) == 0) begin
                exp_q.push_back({2'b10, exp_seq});
                exp_seq++;
            end
            fifo_mem[wr_idx[7:0]] = base + 8'(i);
            wr_idx++;
            exp_q.push_back({1'b0, (i % BL) == BL - 1, base + 8'(i)});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy && !out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_words_left"}, exp_q.size(), 0);
        check({name, "_busy_end"}, busy, 0);
        exp_q.delete();
        tick();
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_alt ? ~out_ready : 1'b1;
        end
    end

    // Monitor: scoreboard pop on transfer, hold-under-stall, occupancy bound, idle gap.
    initial begin
        logic [9:0] e;
        logic       stall_q, after_last, gap_seen;
        logic [8:0] stall_word;
        n_dx = 0; stall_q = 0; after_last = 0; gap_seen = 0; stall_word = '0;
        forever begin
            @(negedge clk);
            if (clear !== 1'b1) begin
                check("occupancy_le_4", (n_pops - n_dx) <= 4, 1);
                if (stall_q) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_hold", {out_last, out_data}, stall_word);
                end
            end
            if (!busy) gap_seen = 1;
            if (out_valid && after_last) begin
                check("idle_gap", gap_seen, 1);
                after_last = 0;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h expected none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check(e[9] ? "header_word" : "data_word", {out_last, out_data}, e[8:0]);
                    if (!e[9]) n_dx++;
                end
                if (out_last) begin
                    after_last = 1;
                    gap_seen   = 0;
                end
            end
            stall_q    = out_valid && !out_ready;
            stall_word = {out_last, out_data};
            if (clear === 1'b1) begin
                n_dx = 0; stall_q = 0; after_last = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (clear !== 1'bx)
                check("rdreq_protocol", fifo_rdreq && (fifo_rdempty || clear || (!en && !busy)), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b1; en = 1'b0; rdy_alt = 1'b0; exp_seq = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rdreq", fifo_rdreq, 0);
        tick();
        clear = 1'b0;
        tick();

        // Basic burst, cycle-accurate against detect cycle 0.
        load_words(8'h10, 0, 4);
        en = 1'b1;
        for (int c = 0; c <= 7 + H; c++) begin
            @(negedge clk);
            check("t1_valid", out_valid, (H == 1 && c == 2) || (c >= 3 + H && c <= 6 + H));
            check("t1_last", out_last, c == 6 + H);
            check("t1_busy", busy, c >= 1 && c <= 6 + H);
            check("t1_rdreq", fifo_rdreq, c >= 1 + H && c <= 4 + H);
            if (c >= 3 + H && c <= 6 + H)
                check("t1_data", out_data, 8'h10 + 8'(c - 3 - H));
        end
        wait_idle("t1");

        // en low in IDLE with data waiting: nothing starts.
        en = 1'b0;
        load_words(8'hD0, 0, 4);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t2_busy_en0", busy, 0);
            check("t2_rdreq_en0", fifo_rdreq, 0);
        end
        tick();
        en = 1'b1;
        wait_idle("t2");

        // Alternating backpressure over two back-to-back bursts.
        rdy_alt = 1'b1;
        load_words(8'hB0, 0, 8);
        wait_idle("t3");
        rdy_alt = 1'b0;
        tick();

        // FIFO runs empty mid-burst for 10 cycles.
        load_words(8'hC0, 0, 2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 7) begin
                check("t4_gap_valid", out_valid, 0);
                check("t4_gap_busy", busy, 1);
            end
        end
        tick();
        load_words(8'hC0, 2, 2);
        wait_idle("t4");

        // clear during the third output word (cycle 5 in both builds).
        load_words(8'h20, 0, 4);
        for (int c = 0; c < 5; c++) tick();
        clear = 1'b1;
        @(negedge clk);
        check("t5_rdreq_in_clear", fifo_rdreq, 0);
        tick();
        clear = 1'b0;
        exp_q.delete();
        exp_seq = '0;
        @(negedge clk);
        check("t5_valid_after", out_valid, 0);
        check("t5_busy_after", busy, 0);
        check("t5_rdreq_after", fifo_rdreq, 0);
        tick();
        load_words(8'h30, 0, 4);
        wait_idle("t5");

        // Fresh sequence numbering over two bursts.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_seq = '0;
        load_words(8'hA0, 0, 8);
        wait_idle("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
